// File: rtl/sodor5_commit_checker.sv
`default_nettype none
// ============================================================================
// Module   : sodor5_cc_fifo
// Purpose  : Small synchronous FIFO holding {rd, data} retire records for one
//            stream of the commit checker.
// Ports    : clk, reset        - clock, asynchronous active-high reset
//            i_push / i_data   - write request and record
//            i_pop             - discard the head record
//            o_head            - record at the head (valid when !o_empty)
//            o_level           - occupancy 0..DEPTH
//            o_empty / o_full  - status flags derived from the pointers
// Revision : 1.0 - initial release
// ============================================================================
module sodor5_cc_fifo #(
    parameter int EW    = 37,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [EW-1:0]              i_data,
    input  logic                       i_pop,
    output logic [EW-1:0]              o_head,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_level = r_wptr - r_rptr;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
endmodule

// ============================================================================
// Module   : sodor5_commit_checker
// Purpose  : Lockstep retire-stream checker. Buffers register writebacks from
//            the core and from the ISA model in separate FIFOs, compares them
//            in program order and latches the first divergence, overflow or
//            starvation as a sticky error.
// Ports    : clk, reset                      - clock, async active-high reset
//            core_wb_valid/rd/data           - core retire stream
//            model_wb_valid/rd/data          - model retire stream
//            err, err_code                   - sticky flag, 1 mism/2 ovf/3 t.o.
//            err_rd_*, err_data_*            - heads captured on a mismatch
//            commit_count                    - matched pairs (wrapping)
//            core_level, model_level         - FIFO occupancies
// Revision : 1.0 - initial release
// ============================================================================
module sodor5_commit_checker #(
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       core_wb_valid,
    input  logic [REG_ADDR_W-1:0]      core_wb_rd,
    input  logic [WORD_SIZE-1:0]       core_wb_data,
    input  logic                       model_wb_valid,
    input  logic [REG_ADDR_W-1:0]      model_wb_rd,
    input  logic [WORD_SIZE-1:0]       model_wb_data,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [REG_ADDR_W-1:0]      err_rd_core,
    output logic [REG_ADDR_W-1:0]      err_rd_model,
    output logic [WORD_SIZE-1:0]       err_data_core,
    output logic [WORD_SIZE-1:0]       err_data_model,
    output logic [31:0]                commit_count,
    output logic [$clog2(DEPTH):0]     core_level,
    output logic [$clog2(DEPTH):0]     model_level
);
    localparam int EW = REG_ADDR_W + WORD_SIZE;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_ERR_NONE     = 2'd0;
    localparam logic [1:0] c_ERR_MISMATCH = 2'd1;
    localparam logic [1:0] c_ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'd3;
    localparam logic [TW-1:0] c_TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_CHECK = 1'b0,
        ST_ERROR = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic [1:0] w_code_nxt;

    logic [1:0]            r_err_code;
    logic [REG_ADDR_W-1:0] r_err_rd_core;
    logic [REG_ADDR_W-1:0] r_err_rd_model;
    logic [WORD_SIZE-1:0]  r_err_data_core;
    logic [WORD_SIZE-1:0]  r_err_data_model;
    logic [31:0]           r_commit_count;
    logic [TW-1:0]         r_to_cnt;

    logic [EW-1:0] w_c_head;
    logic [EW-1:0] w_m_head;
    logic [LW-1:0] w_c_level;
    logic [LW-1:0] w_m_level;
    logic          w_c_empty;
    logic          w_m_empty;
    logic          w_c_full;
    logic          w_m_full;

    logic w_active;
    logic w_pair;
    logic w_match;
    logic w_c_req;
    logic w_m_req;
    logic w_mism;
    logic w_ovf;
    logic w_one_side;
    logic w_to;
    logic w_err_any;
    logic w_commit;
    logic w_c_push;
    logic w_m_push;

    // ------------------------------------------------------------------
    // Event decode. All status comes from registered FIFO pointers, so a
    // record pushed at one edge is only compared at the following edge.
    // ------------------------------------------------------------------
    assign w_active   = (r_state == ST_CHECK);
    assign w_pair     = w_active && !w_c_empty && !w_m_empty;
    assign w_match    = (w_c_head == w_m_head);
    // Writes to x0 are not architectural and are never buffered.
    assign w_c_req    = w_active && core_wb_valid  && (core_wb_rd  != '0);
    assign w_m_req    = w_active && model_wb_valid && (model_wb_rd != '0);
    assign w_mism     = w_pair && !w_match;
    // A full FIFO can accept a push only when its head leaves on the same edge.
    assign w_ovf      = (w_c_req && w_c_full && !w_pair) ||
                        (w_m_req && w_m_full && !w_pair);
    assign w_one_side = w_active && (w_c_empty != w_m_empty);
    assign w_to       = w_one_side && (r_to_cnt == c_TO_LAST);
    assign w_err_any  = w_mism || w_ovf || w_to;

    // The edge that raises an error changes nothing else, so the buffers and
    // counters show the state that led to the failure.
    assign w_commit   = w_pair  && !w_err_any;
    assign w_c_push   = w_c_req && !w_err_any;
    assign w_m_push   = w_m_req && !w_err_any;

    sodor5_cc_fifo #(.EW(EW), .DEPTH(DEPTH)) u_core_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_c_push),
        .i_data  ({core_wb_rd, core_wb_data}),
        .i_pop   (w_commit),
        .o_head  (w_c_head),
        .o_level (w_c_level),
        .o_empty (w_c_empty),
        .o_full  (w_c_full)
    );

    sodor5_cc_fifo #(.EW(EW), .DEPTH(DEPTH)) u_model_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_m_push),
        .i_data  ({model_wb_rd, model_wb_data}),
        .i_pop   (w_commit),
        .o_head  (w_m_head),
        .o_level (w_m_level),
        .o_empty (w_m_empty),
        .o_full  (w_m_full)
    );

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_CHECK;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_err_code;
        case (r_state)
            ST_CHECK: begin
                if (w_err_any) begin
                    w_state_nxt = ST_ERROR;
                    if (w_mism)     w_code_nxt = c_ERR_MISMATCH;
                    else if (w_ovf) w_code_nxt = c_ERR_OVERFLOW;
                    else            w_code_nxt = c_ERR_TIMEOUT;
                end
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt = ST_ERROR;
                w_code_nxt  = c_ERR_NONE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Error capture, commit counter and starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_code       <= c_ERR_NONE;
            r_err_rd_core    <= '0;
            r_err_rd_model   <= '0;
            r_err_data_core  <= '0;
            r_err_data_model <= '0;
            r_commit_count   <= '0;
            r_to_cnt         <= '0;
        end else begin
            r_err_code <= w_code_nxt;
            if (w_active && w_mism) begin
                r_err_rd_core    <= w_c_head[EW-1:WORD_SIZE];
                r_err_rd_model   <= w_m_head[EW-1:WORD_SIZE];
                r_err_data_core  <= w_c_head[WORD_SIZE-1:0];
                r_err_data_model <= w_m_head[WORD_SIZE-1:0];
            end
            if (w_commit) r_commit_count <= r_commit_count + 32'd1;
            // Counts cycles during which only one stream has work waiting.
            if (w_active && !w_err_any) begin
                if (w_one_side) r_to_cnt <= r_to_cnt + TW'(1);
                else            r_to_cnt <= '0;
            end
        end
    end

    assign err            = (r_state == ST_ERROR);
    assign err_code       = r_err_code;
    assign err_rd_core    = r_err_rd_core;
    assign err_rd_model   = r_err_rd_model;
    assign err_data_core  = r_err_data_core;
    assign err_data_model = r_err_data_model;
    assign commit_count   = r_commit_count;
    assign core_level     = w_c_level;
    assign model_level    = w_m_level;
endmodule
`default_nettype wire

// File: tb/tb_sodor5_commit_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sodor5_commit_checker
// Purpose  : Self-checking bench for sodor5_commit_checker: directed table,
//            hand-written corner sequences and randomized streams against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sodor5_commit_checker;
    localparam int WS      = 32;
    localparam int RW      = 5;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           core_wb_valid = 1'b0;
    logic [RW-1:0]  core_wb_rd = '0;
    logic [WS-1:0]  core_wb_data = '0;
    logic           model_wb_valid = 1'b0;
    logic [RW-1:0]  model_wb_rd = '0;
    logic [WS-1:0]  model_wb_data = '0;
    logic           err;
    logic [1:0]     err_code;
    logic [RW-1:0]  err_rd_core;
    logic [RW-1:0]  err_rd_model;
    logic [WS-1:0]  err_data_core;
    logic [WS-1:0]  err_data_model;
    logic [31:0]    commit_count;
    logic [LW-1:0]  core_level;
    logic [LW-1:0]  model_level;

    sodor5_commit_checker #(
        .WORD_SIZE(WS), .REG_ADDR_W(RW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .core_wb_valid  (core_wb_valid),
        .core_wb_rd     (core_wb_rd),
        .core_wb_data   (core_wb_data),
        .model_wb_valid (model_wb_valid),
        .model_wb_rd    (model_wb_rd),
        .model_wb_data  (model_wb_data),
        .err            (err),
        .err_code       (err_code),
        .err_rd_core    (err_rd_core),
        .err_rd_model   (err_rd_model),
        .err_data_core  (err_data_core),
        .err_data_model (err_data_model),
        .commit_count   (commit_count),
        .core_level     (core_level),
        .model_level    (model_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: two record queues plus the sticky error record.
    // ------------------------------------------------------------------
    typedef logic [RW+WS-1:0] ent_t;
    ent_t        cq[$];
    ent_t        mq[$];
    logic [31:0] m_cnt;
    int          m_starve;
    logic        m_err;
    logic [1:0]  m_code;
    logic [RW-1:0] m_erc, m_erm;
    logic [WS-1:0] m_edc, m_edm;

    task automatic model_reset();
        cq.delete();
        mq.delete();
        m_cnt = 0; m_starve = 0; m_err = 0; m_code = 0;
        m_erc = 0; m_erm = 0; m_edc = 0; m_edm = 0;
    endtask

    task automatic model_edge(input logic cv, input logic [RW-1:0] crd, input logic [WS-1:0] cd,
                              input logic mv, input logic [RW-1:0] mrd, input logic [WS-1:0] md);
        bit   both, mism, cpush, mpush, ovf, lonely;
        ent_t hc, hm;
        if (m_err) return;
        both  = (cq.size() > 0) && (mq.size() > 0);
        mism  = 0;
        if (both) begin
            hc = cq[0];
            hm = mq[0];
            mism = (hc != hm);
        end
        cpush  = cv && (crd != 0);
        mpush  = mv && (mrd != 0);
        ovf    = (cpush && cq.size() == DEPTH && !both) || (mpush && mq.size() == DEPTH && !both);
        lonely = (cq.size() > 0) != (mq.size() > 0);
        if (mism) begin
            m_err = 1; m_code = 1;
            m_erc = hc[RW+WS-1:WS]; m_erm = hm[RW+WS-1:WS];
            m_edc = hc[WS-1:0];     m_edm = hm[WS-1:0];
        end else if (ovf) begin
            m_err = 1; m_code = 2;
        end else if (lonely && m_starve + 1 >= TIMEOUT) begin
            m_err = 1; m_code = 3;
        end else begin
            if (both) begin
                void'(cq.pop_front());
                void'(mq.pop_front());
                m_cnt = m_cnt + 1;
            end
            if (cpush) cq.push_back({crd, cd});
            if (mpush) mq.push_back({mrd, md});
            m_starve = lonely ? m_starve + 1 : 0;
        end
    endtask

    task automatic compare_all();
        chk("err",            32'(err),            32'(m_err));
        chk("err_code",       32'(err_code),       32'(m_code));
        chk("err_rd_core",    32'(err_rd_core),    32'(m_erc));
        chk("err_rd_model",   32'(err_rd_model),   32'(m_erm));
        chk("err_data_core",  err_data_core,       m_edc);
        chk("err_data_model", err_data_model,      m_edm);
        chk("commit_count",   commit_count,        m_cnt);
        chk("core_level",     32'(core_level),     32'(cq.size()));
        chk("model_level",    32'(model_level),    32'(mq.size()));
    endtask

    // One clock: drive on the falling edge, check 1 ns after the rising edge.
    task automatic step(input logic cv, input logic [RW-1:0] crd, input logic [WS-1:0] cd,
                        input logic mv, input logic [RW-1:0] mrd, input logic [WS-1:0] md);
        @(negedge clk);
        core_wb_valid  = cv;  core_wb_rd  = crd; core_wb_data  = cd;
        model_wb_valid = mv;  model_wb_rd = mrd; model_wb_data = md;
        @(posedge clk);
        model_edge(cv, crd, cd, mv, mrd, md);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Reset pulse placed between clock edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        core_wb_valid = 1'b0; model_wb_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1 reset = 1'b0;
    endtask

    typedef struct {
        bit            rst_before;
        logic          cv;
        logic [RW-1:0] crd;
        logic [WS-1:0] cd;
        logic          mv;
        logic [RW-1:0] mrd;
        logic [WS-1:0] md;
        int            ecnt;
        int            ecl;
        int            eml;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    v;
        ent_t    pend[$];
        ent_t    e;
        logic    mv;
        logic [RW-1:0] rd;
        logic [WS-1:0] dv;
        int      pc, pm;

        model_reset();
        #12 reset = 1'b0;
        do_reset();

        // ---------------- table: lockstep then skewed latency ----------------
        for (int k = 0; k < 6; k++) begin
            v = '{rst_before: (k == 0), cv: (k < 5), crd: RW'(k + 1), cd: 32'h11111111 * (k + 1),
                  mv: (k < 5), mrd: RW'(k + 1), md: 32'h11111111 * (k + 1),
                  ecnt: k, ecl: (k < 5) ? 1 : 0, eml: (k < 5) ? 1 : 0};
            vecs.push_back(v);
        end
        for (int t = 0; t < 11; t++) begin
            v.rst_before = (t == 0);
            v.cv  = (t < 4);
            v.crd = RW'(t + 8);
            v.cd  = 32'hA5A50000 + t;
            v.mv  = (t >= 6 && t <= 9);
            v.mrd = RW'(t + 2);
            v.md  = 32'hA5A50000 + t - 6;
            v.ecnt = (t <= 6) ? 0 : t - 6;
            v.ecl  = (t < 4) ? t + 1 : (t <= 6) ? 4 : 10 - t;
            v.eml  = (t >= 6 && t <= 9) ? 1 : 0;
            vecs.push_back(v);
        end
        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            step(vecs[i].cv, vecs[i].crd, vecs[i].cd, vecs[i].mv, vecs[i].mrd, vecs[i].md);
            chk("tbl_count", commit_count, 32'(vecs[i].ecnt));
            chk("tbl_core_level", 32'(core_level), 32'(vecs[i].ecl));
            chk("tbl_model_level", 32'(model_level), 32'(vecs[i].eml));
            chk("tbl_err", 32'(err), 32'd0);
        end

        // ---------------- data mismatch ----------------
        do_reset();
        step(1'b1, 5'd5, 32'h12345678, 1'b1, 5'd5, 32'h12345678);
        step(1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 5'd7, 32'hDEADBEEE);
        idle();
        chk("mism_err", 32'(err), 32'd1);
        chk("mism_code", 32'(err_code), 32'd1);
        chk("mism_data_core", err_data_core, 32'hDEADBEEF);
        chk("mism_data_model", err_data_model, 32'hDEADBEEE);
        chk("mism_rd_core", 32'(err_rd_core), 32'd7);
        chk("mism_count", commit_count, 32'd1);
        step(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h1);
        idle();
        chk("mism_count_frozen", commit_count, 32'd1);

        // ---------------- x0 filtering plus overflow ----------------
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 5'd0, $urandom, 1'b0, '0, '0);
        chk("x0_level", 32'(core_level), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 5'd3, 32'h300 + i, 1'b0, '0, '0);
        chk("ovf_pre_err", 32'(err), 32'd0);
        chk("ovf_pre_level", 32'(core_level), 32'd8);
        step(1'b1, 5'd3, 32'h308, 1'b0, '0, '0);
        chk("ovf_code", 32'(err_code), 32'd2);
        chk("ovf_level", 32'(core_level), 32'd8);
        chk("ovf_data_core", err_data_core, 32'd0);

        // ---------------- timeout ----------------
        do_reset();
        step(1'b1, 5'd2, 32'h22, 1'b0, '0, '0);
        chk("to_visible", 32'(core_level), 32'd1);
        for (int i = 0; i < TIMEOUT - 1; i++) idle();
        chk("to_not_yet", 32'(err), 32'd0);
        idle();
        chk("to_err", 32'(err), 32'd1);
        chk("to_code", 32'(err_code), 32'd3);

        // ---------------- reset mid-operation ----------------
        do_reset();
        step(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h44);
        for (int i = 1; i <= 3; i++) step(1'b1, RW'(i), 32'h1000 + i, 1'b0, '0, '0);
        chk("mid_level", 32'(core_level), 32'd3);
        chk("mid_count", commit_count, 32'd1);
        do_reset();
        chk("rst_level", 32'(core_level), 32'd0);
        chk("rst_count", commit_count, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        step(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h66);
        idle();
        chk("post_rst_count", commit_count, 32'd1);

        // ---------------- randomized streams ----------------
        for (int seg = 0; seg < 25; seg++) begin
            do_reset();
            pend.delete();
            pc = $urandom_range(20, 80);
            pm = (seg % 5 == 4) ? 0 : $urandom_range(20, 80);
            for (int c = 0; c < 80; c++) begin
                logic cv;
                cv = ($urandom_range(0, 99) < pc);
                rd = RW'($urandom_range(0, 31));
                dv = $urandom;
                if (cv) pend.push_back({rd, dv});
                mv = 1'b0;
                e  = '0;
                if (pend.size() > 0 && $urandom_range(0, 99) < pm) begin
                    e  = pend.pop_front();
                    mv = 1'b1;
                    if ($urandom_range(0, 199) == 0) e[0] = ~e[0];
                end
                step(cv, rd, dv, mv, e[RW+WS-1:WS], e[WS-1:0]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
